// File: rtl/led_scan_capture_if.sv
// Pin-side bundle for led_scan_capture: scan inputs, frame handshake, row read port
// and status flags. The monitor consumes the bundle through the slave modport.
interface led_scan_capture_if #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int CNT_W   = 8
);
    logic               en;
    logic [WIDTH-1:0]   row;
    logic [WIDTH-1:0]   col;
    logic               frame_ack;
    logic               clr_err;
    logic [REGBITS-1:0] rd_addr;
    logic [WIDTH-1:0]   rd_row;
    logic               frame_valid;
    logic               frame_changed;
    logic               still_life;
    logic [CNT_W-1:0]   frame_count;
    logic               err_onehot;
    logic               err_seq;
    logic               overrun;

    modport master (
        output en, row, col, frame_ack, clr_err, rd_addr,
        input  rd_row, frame_valid, frame_changed, still_life, frame_count,
               err_onehot, err_seq, overrun
    );

    modport slave (
        input  en, row, col, frame_ack, clr_err, rd_addr,
        output rd_row, frame_valid, frame_changed, still_life, frame_count,
               err_onehot, err_seq, overrun
    );
endinterface

// File: rtl/led_scan_capture.sv
// Rebuilds WIDTH x WIDTH frames from a multiplexed row/col scan, checks scan order,
// and presents each finished frame through a valid/ack handshake with a row read port.
module led_scan_capture #(
    parameter int WIDTH         = 8,
    parameter int REGBITS       = 3,
    parameter int STABLE_FRAMES = 4,
    parameter int CNT_W         = 8
) (
    input logic               ph1,
    input logic               ph2,
    input logic               reset,
    led_scan_capture_if.slave bus
);
    localparam int            SW         = $clog2(STABLE_FRAMES + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);

    typedef enum logic {HUNT = 1'b0, CAPTURE = 1'b1} fsm_e;

    typedef struct packed {
        fsm_e                        fsm;
        logic [REGBITS-1:0]          nexp;
        logic                        pend;
        logic [WIDTH-1:0][WIDTH-1:0] work;
        logic [WIDTH-1:0][WIDTH-1:0] disp;
        logic                        valid;
        logic                        changed;
        logic [SW-1:0]               stable;
        logic [CNT_W-1:0]            count;
        logic                        err_onehot;
        logic                        err_seq;
        logic                        overrun;
    } st_t;

    st_t                r_m;
    st_t                r_s;
    st_t                w_nxt;
    logic               w_onehot;
    logic [REGBITS-1:0] w_idx;
    logic [WIDTH-1:0]   w_data;

    // Master half samples inputs on ph2, slave half publishes on ph1.
    always_ff @(posedge ph2) begin
        if (!reset) r_m <= '0;
        else        r_m <= w_nxt;
    end

    always_ff @(posedge ph1) r_s <= r_m;

    always_comb begin
        w_onehot = (bus.row != '0) && ((bus.row & (bus.row - 1'b1)) == '0);
        w_idx    = '0;
        for (int i = 0; i < WIDTH; i++)
            if (bus.row[i]) w_idx = REGBITS'(i);
        w_data = ~bus.col;
    end

    always_comb begin
        w_nxt      = r_s;
        w_nxt.pend = 1'b0;

        if (bus.clr_err) begin
            w_nxt.err_onehot = 1'b0;
            w_nxt.err_seq    = 1'b0;
            w_nxt.overrun    = 1'b0;
        end

        if (bus.en) begin
            if (!w_onehot) begin
                w_nxt.err_onehot = 1'b1;
                w_nxt.fsm        = HUNT;
            end else begin
                case (r_s.fsm)
                    HUNT: begin
                        if (w_idx == '0) begin
                            w_nxt.work[0] = w_data;
                            w_nxt.nexp    = REGBITS'(1);
                            w_nxt.fsm     = CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (w_idx == r_s.nexp - 1'b1) begin
                            w_nxt.work[w_idx] = w_data;
                        end else if (w_idx == r_s.nexp) begin
                            w_nxt.work[w_idx] = w_data;
                            if (w_idx == REGBITS'(WIDTH - 1)) begin
                                w_nxt.pend = 1'b1;
                                w_nxt.fsm  = HUNT;
                            end else begin
                                w_nxt.nexp = r_s.nexp + 1'b1;
                            end
                        end else begin
                            w_nxt.err_seq = 1'b1;
                            if (w_idx == '0) begin
                                w_nxt.work[0] = w_data;
                                w_nxt.nexp    = REGBITS'(1);
                            end else begin
                                w_nxt.fsm = HUNT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Commit reads the registered working buffer, so a row 0 of the next
        // frame arriving in the same cycle does not leak into this frame.
        if (r_s.pend) begin
            if (r_s.valid && !bus.frame_ack) begin
                w_nxt.overrun = 1'b1;
            end else begin
                w_nxt.disp    = r_s.work;
                w_nxt.valid   = 1'b1;
                w_nxt.count   = r_s.count + 1'b1;
                w_nxt.changed = (r_s.work != r_s.disp);
                if (r_s.work != r_s.disp)      w_nxt.stable = SW'(1);
                else if (r_s.stable != STABLE_MAX) w_nxt.stable = r_s.stable + 1'b1;
            end
        end else if (bus.frame_ack) begin
            w_nxt.valid = 1'b0;
        end
    end

    assign bus.rd_row        = r_s.disp[bus.rd_addr];
    assign bus.frame_valid   = r_s.valid;
    assign bus.frame_changed = r_s.changed;
    assign bus.still_life    = (r_s.stable == STABLE_MAX);
    assign bus.frame_count   = r_s.count;
    assign bus.err_onehot    = r_s.err_onehot;
    assign bus.err_seq       = r_s.err_seq;
    assign bus.overrun       = r_s.overrun;
endmodule

// File: tb/tb_led_scan_capture.sv
// Directed scenarios plus randomized scan traffic, checked against a frame-level model.
module tb_led_scan_capture;
    logic ph1 = 1'b0, ph2 = 1'b0, reset = 1'b0;
    led_scan_capture_if #(.WIDTH(8), .REGBITS(3), .CNT_W(8)) bus ();
    led_scan_capture #(.WIDTH(8), .REGBITS(3), .STABLE_FRAMES(4), .CNT_W(8)) dut (
        .ph1(ph1), .ph2(ph2), .reset(reset), .bus(bus)
    );

    int total = 0, bad = 0;

    initial forever begin
        #1 ph2 = 1'b1; #4 ph2 = 1'b0; #5 ph1 = 1'b1; #4 ph1 = 1'b0; #26;
    end

    logic [63:0] fa = 64'h0000_0000_0010_3018;
    logic [63:0] fb = 64'h8142_2418_1824_4281;
    logic [63:0] fc = 64'h0000_0000_5A5A_5A5A;
    logic [63:0] fd = 64'h0F0F_0F0F_0000_0000;

    // Frame-level model: state after each cycle edge.
    bit          m_hunt = 1'b1, m_pend, m_valid, m_changed, m_eo, m_es, m_ov;
    int          m_exp, m_stable, m_count;
    logic [63:0] m_work, m_disp;

    task automatic model_upd(input bit en, input logic [7:0] row, col,
                             input bit ack, clr, rst);
        logic [63:0] frame;
        bit          commit;
        int          r;
        if (!rst) begin
            m_hunt = 1; m_exp = 0; m_pend = 0; m_work = '0; m_disp = '0;
            m_valid = 0; m_changed = 0; m_eo = 0; m_es = 0; m_ov = 0;
            m_stable = 0; m_count = 0;
            return;
        end
        frame  = m_work;
        commit = m_pend;
        m_pend = 0;
        if (clr) begin m_eo = 0; m_es = 0; m_ov = 0; end
        if (en && $countones(row) != 1) begin
            m_eo = 1; m_hunt = 1;
        end else if (en) begin
            r = $clog2(row);
            if (m_hunt || (r != m_exp && r != m_exp - 1)) begin
                if (!m_hunt) m_es = 1;
                m_hunt = (r != 0);
                if (r == 0) begin m_work[7:0] = ~col; m_exp = 1; end
            end else begin
                m_work[8*r +: 8] = ~col;
                if (r == m_exp && r == 7) begin m_pend = 1; m_hunt = 1; end
                else if (r == m_exp) m_exp++;
            end
        end
        if (commit && m_valid && !ack) m_ov = 1;
        else if (commit) begin
            m_changed = (frame != m_disp);
            m_disp    = frame;
            m_valid   = 1;
            m_count   = (m_count + 1) % 256;
            m_stable  = m_changed ? 1 : ((m_stable < 4) ? m_stable + 1 : 4);
        end else if (ack) m_valid = 0;
    endtask

    function automatic logic [13:0] m_vec();
        return {m_valid, m_changed, m_stable == 4, 8'(m_count), m_eo, m_es, m_ov};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {bus.frame_valid, bus.frame_changed, bus.still_life, bus.frame_count,
                bus.err_onehot, bus.err_seq, bus.overrun};
    endfunction

    task automatic cyc(input bit en, input logic [7:0] row, col,
                       input bit ack = 0, input bit clr = 0, input bit rst = 1);
        bus.en = en; bus.row = row; bus.col = col;
        bus.frame_ack = ack; bus.clr_err = clr; reset = rst;
        @(negedge ph1);
        model_upd(en, row, col, ack, clr, rst);
    endtask

    task automatic scan(input logic [63:0] f, input bit ack = 0);
        for (int r = 0; r < 8; r++) cyc(1, 8'(1 << r), ~f[8*r +: 8], ack);
    endtask

    task automatic test_reset();
        bus.rd_addr = '0;
        cyc(0, 8'h00, 8'hFF, 0, 0, 0);
        cyc(0, 8'h00, 8'hFF, 0, 0, 0);
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), 14'd0);
        end
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a); #1;
            total++;
            if (bus.rd_row !== 8'h00) begin
                bad++; $display("FAIL reset_rd_row%0d got=%h exp=00", a, bus.rd_row);
            end
        end
    endtask

    task automatic test_basic();
        scan(fa);
        total++;
        if (bus.frame_valid !== 1'b0) begin
            bad++; $display("FAIL basic_early_valid got=%b exp=0", bus.frame_valid);
        end
        cyc(0, 8'h00, 8'hFF);
        total++;
        if ({bus.frame_valid, bus.frame_changed, bus.frame_count} !== {1'b1, 1'b1, 8'd1}) begin
            bad++; $display("FAIL basic_commit got=%b/%b/%0d exp=1/1/1",
                            bus.frame_valid, bus.frame_changed, bus.frame_count);
        end
        for (int a = 0; a < 3; a++) begin
            bus.rd_addr = 3'(a); #1;
            total++;
            if (bus.rd_row !== fa[8*a +: 8]) begin
                bad++; $display("FAIL basic_rd_row%0d got=%h exp=%h", a, bus.rd_row, fa[8*a +: 8]);
            end
        end
    endtask

    task automatic test_still_life();
        cyc(0, 8'h00, 8'hFF, 1);
        for (int k = 0; k < 4; k++) begin
            scan(fa, 1);
            cyc(0, 8'h00, 8'hFF);
            total++;
            if (bus.frame_changed !== 1'b0 || dut_vec() !== m_vec()) begin
                bad++; $display("FAIL still_repeat%0d got=%h exp=%h", k, dut_vec(), m_vec());
            end
        end
        total++;
        if (bus.still_life !== 1'b1) begin
            bad++; $display("FAIL still_set got=%b exp=1", bus.still_life);
        end
        scan(fb, 1);
        cyc(0, 8'h00, 8'hFF);
        total++;
        if ({bus.still_life, bus.frame_changed} !== 2'b01) begin
            bad++; $display("FAIL still_clear got=%b%b exp=01", bus.still_life, bus.frame_changed);
        end
    endtask

    task automatic test_onehot();
        int cnt0;
        cyc(0, 8'h00, 8'hFF, 1, 1);
        cnt0 = m_count;
        cyc(1, 8'h01, 8'h00); cyc(1, 8'h02, 8'h00); cyc(1, 8'h04, 8'h00);
        cyc(1, 8'h03, 8'hFF);
        cyc(0, 8'h00, 8'hFF);
        total++;
        if ({bus.err_onehot, bus.frame_valid, bus.frame_count} !== {1'b1, 1'b0, 8'(cnt0)}) begin
            bad++; $display("FAIL onehot_flag got=%b/%b/%0d exp=1/0/%0d",
                            bus.err_onehot, bus.frame_valid, bus.frame_count, cnt0);
        end
        scan(fc);
        cyc(0, 8'h00, 8'hFF);
        total++;
        if ({bus.err_onehot, bus.frame_valid, bus.frame_count} !== {1'b1, 1'b1, 8'(cnt0 + 1)}) begin
            bad++; $display("FAIL onehot_recover got=%b/%b/%0d exp=1/1/%0d",
                            bus.err_onehot, bus.frame_valid, bus.frame_count, cnt0 + 1);
        end
        cyc(0, 8'h00, 8'hFF, 1, 1);
        total++;
        if (bus.err_onehot !== 1'b0) begin
            bad++; $display("FAIL onehot_clear got=%b exp=0", bus.err_onehot);
        end
    endtask

    task automatic test_seq();
        int cnt0;
        cyc(0, 8'h00, 8'hFF, 1, 1);
        cnt0 = m_count;
        cyc(1, 8'h01, 8'h00); cyc(1, 8'h02, 8'h00); cyc(1, 8'h08, 8'h00);
        total++;
        if (bus.err_seq !== 1'b1) begin
            bad++; $display("FAIL seq_flag got=%b exp=1", bus.err_seq);
        end
        for (int r = 4; r < 8; r++) cyc(1, 8'(1 << r), 8'h00);
        cyc(0, 8'h00, 8'hFF);
        total++;
        if ({bus.frame_valid, bus.frame_count} !== {1'b0, 8'(cnt0)}) begin
            bad++; $display("FAIL seq_no_commit got=%b/%0d exp=0/%0d",
                            bus.frame_valid, bus.frame_count, cnt0);
        end
        scan(fb);
        cyc(0, 8'h00, 8'hFF, 0, 1);
        total++;
        if ({bus.frame_count, bus.err_seq} !== {8'(cnt0 + 1), 1'b0}) begin
            bad++; $display("FAIL seq_recover got=%0d/%b exp=%0d/0", bus.frame_count, bus.err_seq, cnt0 + 1);
        end
        cyc(0, 8'h00, 8'hFF, 1);
        for (int r = 0; r < 8; r++) begin
            cyc(1, 8'(1 << r), ~fa[8*r +: 8]);
            cyc(1, 8'(1 << r), ~fa[8*r +: 8]);
        end
        cyc(0, 8'h00, 8'hFF);
        total++;
        if ({bus.frame_count, bus.err_seq, bus.err_onehot} !== {8'(cnt0 + 2), 2'b00}) begin
            bad++; $display("FAIL seq_slow_scan got=%0d/%b/%b exp=%0d/0/0",
                            bus.frame_count, bus.err_seq, bus.err_onehot, cnt0 + 2);
        end
    endtask

    task automatic test_overrun();
        int cnt0;
        cyc(0, 8'h00, 8'hFF, 1, 1);
        cnt0 = m_count;
        scan(fc); cyc(0, 8'h00, 8'hFF);
        scan(fd); cyc(0, 8'h00, 8'hFF);
        total++;
        if ({bus.overrun, bus.frame_valid, bus.frame_count} !== {1'b1, 1'b1, 8'(cnt0 + 1)}) begin
            bad++; $display("FAIL overrun_flag got=%b/%b/%0d exp=1/1/%0d",
                            bus.overrun, bus.frame_valid, bus.frame_count, cnt0 + 1);
        end
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a); #1;
            total++;
            if (bus.rd_row !== fc[8*a +: 8]) begin
                bad++; $display("FAIL overrun_hold_row%0d got=%h exp=%h", a, bus.rd_row, fc[8*a +: 8]);
            end
        end
        cyc(0, 8'h00, 8'hFF, 0, 1);
        scan(fd);
        cyc(0, 8'h00, 8'hFF, 1);
        total++;
        if ({bus.overrun, bus.frame_valid, bus.frame_count} !== {1'b0, 1'b1, 8'(cnt0 + 2)}) begin
            bad++; $display("FAIL ack_at_commit got=%b/%b/%0d exp=0/1/%0d",
                            bus.overrun, bus.frame_valid, bus.frame_count, cnt0 + 2);
        end
        bus.rd_addr = 3'd7; #1;
        total++;
        if (bus.rd_row !== fd[63:56]) begin
            bad++; $display("FAIL ack_at_commit_row got=%h exp=%h", bus.rd_row, fd[63:56]);
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 4; r++) cyc(1, 8'(1 << r), ~fc[8*r +: 8]);
        cyc(1, 8'h10, ~fc[39:32], 0, 0, 0);
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++; $display("FAIL midreset_outputs got=%h exp=%h", dut_vec(), 14'd0);
        end
        scan(fd);
        cyc(0, 8'h00, 8'hFF);
        total++;
        if ({bus.frame_valid, bus.frame_changed, bus.frame_count} !== {1'b1, 1'b1, 8'd1}) begin
            bad++; $display("FAIL midreset_commit got=%b/%b/%0d exp=1/1/1",
                            bus.frame_valid, bus.frame_changed, bus.frame_count);
        end
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a); #1;
            total++;
            if (bus.rd_row !== fd[8*a +: 8]) begin
                bad++; $display("FAIL midreset_row%0d got=%h exp=%h", a, bus.rd_row, fd[8*a +: 8]);
            end
        end
    endtask

    task automatic test_random();
        int          nr = 0, r, sel;
        logic [63:0] cur = fa;
        logic [7:0]  row, col;
        bit          en;
        for (int i = 0; i < 500; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                row = 8'($urandom); col = 8'($urandom);
            end else if (sel == 1) begin
                r = $urandom_range(0, 7); row = 8'(1 << r); col = 8'($urandom);
            end else if (sel < 5) begin
                r = (nr + 7) % 8; row = 8'(1 << r); col = ~cur[8*r +: 8];
            end else begin
                r = nr; row = 8'(1 << r); col = ~cur[8*r +: 8];
                if (en) begin
                    nr = (nr + 1) % 8;
                    if (nr == 0) cur = ($urandom_range(0, 3) == 0) ? fb : fa;
                end
            end
            cyc(en, row, col, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 149) != 0);
            total++;
            if (dut_vec() !== m_vec()) begin
                bad++; $display("FAIL random_status cyc%0d got=%h exp=%h", i, dut_vec(), m_vec());
            end
            bus.rd_addr = 3'($urandom_range(0, 7)); #1;
            total++;
            if (bus.rd_row !== m_disp[8*bus.rd_addr +: 8]) begin
                bad++; $display("FAIL random_rd_row cyc%0d got=%h exp=%h",
                                i, bus.rd_row, m_disp[8*bus.rd_addr +: 8]);
            end
        end
    endtask

    initial begin
        bus.en = 0; bus.row = '0; bus.col = '1; bus.frame_ack = 0;
        bus.clr_err = 0; bus.rd_addr = '0;
        test_reset();
        test_basic();
        test_still_life();
        test_onehot();
        test_seq();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
